// File: rtl/nios_system_pio_out_if.sv
// Avalon-MM slave bus bundle for the output PIO.
// The master drives address/strobes/data; the slave returns readdata.
interface nios_system_pio_out_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios_system_pio_out.sv
// Avalon-MM output PIO: data register with set/clear aliases, plus an
// optional one-shot pulse engine with irq, built when PIO_OUT_PULSE_EN is defined.
module nios_system_pio_out #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int              PULSE_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nios_system_pio_out_if.slave bus,
  output logic [WIDTH-1:0]     out_port,
  output logic                 irq
);

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_LEN  = 3'd1;
  localparam logic [2:0] A_GO   = 3'd2;
  localparam logic [2:0] A_STAT = 3'd3;
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CLR  = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_reg;
  logic [31:0]      rd_nxt;
  logic             unused;

  assign wr     = bus.chipselect & ~bus.write_n;
  assign wd     = bus.writedata[WIDTH-1:0];
  assign unused = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= RESET_VALUE;
    end else begin
      unique case (1'b1)
        wr && bus.address == A_DATA: data_reg <= wd;
        wr && bus.address == A_SET:  data_reg <= data_reg | wd;
        wr && bus.address == A_CLR:  data_reg <= data_reg & ~wd;
        default: ;
      endcase
    end
  end

`ifdef PIO_OUT_PULSE_EN
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [PULSE_CNT_W-1:0] CNT_ONE = 1;

  state_t                 state, state_nxt;
  logic [PULSE_CNT_W-1:0] pulse_len;
  logic [PULSE_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]       pulse_mask;
  logic                   done, overrun, irq_en, irq_q;
  logic                   go_wr, stat_wr;
  logic                   start, finish, busy;

  assign go_wr   = wr && bus.address == A_GO;
  assign stat_wr = wr && bus.address == A_STAT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (go_wr && |wd) state_nxt = ACTIVE;
      ACTIVE: if (cnt == '0)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start  = 1'b0;
    finish = 1'b0;
    busy   = 1'b0;
    unique case (state)
      IDLE:   start = go_wr && |wd;
      ACTIVE: begin
        busy   = 1'b1;
        finish = (cnt == '0);
      end
      default: ;
    endcase
  end

  // A zero length is treated as a one-clock pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_len  <= '0;
      cnt        <= '0;
      pulse_mask <= '0;
    end else begin
      if (wr && bus.address == A_LEN)
        pulse_len <= bus.writedata[PULSE_CNT_W-1:0];
      if (start) begin
        pulse_mask <= wd;
        cnt        <= (pulse_len == '0) ? '0 : pulse_len - CNT_ONE;
      end else if (finish) begin
        pulse_mask <= '0;
      end else if (busy) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  // Hardware set beats a same-cycle software clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done    <= 1'b0;
      overrun <= 1'b0;
      irq_en  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (finish)
        done <= 1'b1;
      else if (stat_wr && bus.writedata[1])
        done <= 1'b0;
      if (go_wr && busy)
        overrun <= 1'b1;
      else if (stat_wr && bus.writedata[2])
        overrun <= 1'b0;
      if (stat_wr)
        irq_en <= bus.writedata[8];
      irq_q <= done & irq_en;
    end
  end

  assign out_port = data_reg | pulse_mask;
  assign irq      = irq_q;

  always_comb begin
    rd_nxt = '0;
    unique case (bus.address)
      A_DATA: rd_nxt[WIDTH-1:0]       = data_reg;
      A_LEN:  rd_nxt[PULSE_CNT_W-1:0] = pulse_len;
      A_GO:   rd_nxt[WIDTH-1:0]       = pulse_mask;
      A_STAT: begin
        rd_nxt[0] = busy;
        rd_nxt[1] = done;
        rd_nxt[2] = overrun;
        rd_nxt[8] = irq_en;
      end
      default: ;
    endcase
  end
`else
  assign out_port = data_reg;
  assign irq      = 1'b0;

  always_comb begin
    rd_nxt = '0;
    if (bus.address == A_DATA)
      rd_nxt[WIDTH-1:0] = data_reg;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rd_nxt;
  end

endmodule

// File: tb/tb_nios_system_pio_out.sv
// Scoreboard bench for nios_system_pio_out: directed bus traffic pushes
// expected readdata / port values, a negedge monitor pops and compares.
module tb_nios_system_pio_out;
  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] out_port;
  logic         irq;

  nios_system_pio_out_if bus();

  nios_system_pio_out #(
    .WIDTH(W),
    .RESET_VALUE(RV),
    .PULSE_CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .out_port(out_port),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t rd_q[$];
  exp_t port_q[$];
  int   tests = 0;
  int   failed = 0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  logic port_req = 1'b0;

  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    exp_t e;
    if (port_req) begin
      tests++;
      if (port_q.size() == 0) begin
        failed++;
        $display("FAIL port_q_empty: got out_port=%h, want a queued value", out_port);
      end else begin
        e = port_q.pop_front();
        if ({23'b0, irq, out_port} !== e.exp) begin
          failed++;
          $display("FAIL %s: got irq=%0b out_port=%h, want irq=%0b out_port=%h",
                   e.name, irq, out_port, e.exp[8], e.exp[7:0]);
        end
      end
    end
    if (rd_vld) begin
      tests++;
      if (rd_q.size() == 0) begin
        failed++;
        $display("FAIL rd_q_empty: got readdata=%h, want a queued value", bus.readdata);
      end else begin
        e = rd_q.pop_front();
        if (bus.readdata !== e.exp) begin
          failed++;
          $display("FAIL %s: got readdata=%h, want %h", e.name, bus.readdata, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    rd_req         = 1'b0;
    port_req       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    tick();
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] x, input string n);
    exp_t e;
    tick();
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    rd_req         = 1'b1;
    e.exp  = x;
    e.name = n;
    rd_q.push_back(e);
  endtask

  task automatic expect_port(input logic [W-1:0] p, input logic i, input string n);
    exp_t e;
    e.exp    = {23'b0, i, p};
    e.name   = n;
    port_req = 1'b1;
    port_q.push_back(e);
  endtask

  task automatic chk(input logic [W-1:0] p, input logic i, input string n);
    tick();
    expect_port(p, i, n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of run, want finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    reset_n        = 1'b0;

    chk(RV, 1'b0, "reset_port");
    rd(3'd0, 32'h0, "reset_readdata");
    tick();
    reset_n = 1'b1;
    rd(3'd0, {24'h0, RV}, "read_data_reset");
    rd(3'd3, 32'h0, "read_status_reset");

    wr(3'd0, 32'h0F);
    chk(8'h0F, 1'b0, "data_write");
    wr(3'd4, 32'hF0);
    chk(8'hFF, 1'b0, "outset");
    wr(3'd5, 32'h3C);
    chk(8'hC3, 1'b0, "outclear");
    rd(3'd0, 32'h0000_00C3, "read_data");
    wr(3'd4, 32'hFFFF_FF00);
    chk(8'hC3, 1'b0, "outset_upper_ignored");
    wr(3'd6, 32'hFF);
    wr(3'd7, 32'h00);
    chk(8'hC3, 1'b0, "addr67_ignored");
    tick();
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b0;
    bus.writedata  = 32'h0;
    chk(8'hC3, 1'b0, "no_chipselect");
    rd(3'd4, 32'h0, "read_outset");
    rd(3'd5, 32'h0, "read_outclear");
    rd(3'd6, 32'h0, "read_addr6");

`ifdef PIO_OUT_PULSE_EN
    wr(3'd0, 32'h0);
    wr(3'd1, 32'd5);
    wr(3'd3, 32'h100);
    rd(3'd1, 32'd5, "read_len");
    rd(3'd3, 32'h100, "read_irq_en");
    wr(3'd2, 32'h81);
    for (int i = 0; i < 5; i++) chk(8'h81, 1'b0, "pulse_high");
    chk(8'h00, 1'b0, "pulse_end");
    chk(8'h00, 1'b1, "irq_rise");
    rd(3'd3, 32'h102, "status_done");
    wr(3'd3, 32'h102);
    chk(8'h00, 1'b1, "irq_hold");
    chk(8'h00, 1'b0, "irq_clear");
    wr(3'd3, 32'h0);

    wr(3'd1, 32'd0);
    wr(3'd2, 32'h04);
    chk(8'h04, 1'b0, "len0_high");
    chk(8'h00, 1'b0, "len0_low");
    rd(3'd3, 32'h2, "len0_done");
    wr(3'd3, 32'h2);
    wr(3'd2, 32'h0);
    chk(8'h00, 1'b0, "go_zero");
    rd(3'd3, 32'h0, "go_zero_idle");

    wr(3'd1, 32'hFFFF);
    wr(3'd2, 32'h10);
    chk(8'h10, 1'b0, "long_first");
    idle(65533);
    chk(8'h10, 1'b0, "long_last");
    chk(8'h00, 1'b0, "long_end");
    wr(3'd3, 32'h2);

    wr(3'd1, 32'd10);
    wr(3'd2, 32'h01);
    chk(8'h01, 1'b0, "ovr_c1");
    rd(3'd2, 32'h01, "read_mask");
    wr(3'd2, 32'h02);
    chk(8'h01, 1'b0, "ovr_c4");
    idle(5);
    chk(8'h01, 1'b0, "ovr_last");
    chk(8'h00, 1'b0, "ovr_end");
    rd(3'd3, 32'h6, "ovr_status");
    wr(3'd3, 32'h6);

    wr(3'd1, 32'd2);
    wr(3'd2, 32'h01);
    tick();
    wr(3'd3, 32'h2);
    rd(3'd3, 32'h2, "done_set_wins");

    wr(3'd3, 32'h6);
    wr(3'd2, 32'h01);
    tick();
    tick();
    wr(3'd2, 32'h02);
    rd(3'd3, 32'h6, "b2b_overrun");
    chk(8'h00, 1'b0, "b2b_no_retrigger");
    wr(3'd3, 32'h6);

    wr(3'd1, 32'd10);
    wr(3'd2, 32'h0C);
    chk(8'h0C, 1'b0, "rst_pulse_c1");
    idle(2);
    tick();
    reset_n = 1'b0;
    expect_port(RV, 1'b0, "async_reset");
    tick();
    reset_n = 1'b1;
    rd(3'd3, 32'h0, "reset_busy");
    rd(3'd2, 32'h0, "reset_mask");
    chk(RV, 1'b0, "after_reset");
    rd(3'd1, 32'h0, "reset_len");
`else
    wr(3'd1, 32'd5);
    wr(3'd2, 32'hFF);
    wr(3'd3, 32'h106);
    chk(8'hC3, 1'b0, "nopulse_port");
    rd(3'd1, 32'h0, "nopulse_len");
    rd(3'd2, 32'h0, "nopulse_go");
    rd(3'd3, 32'h0, "nopulse_status");
    chk(8'hC3, 1'b0, "nopulse_irq");
    tick();
    reset_n = 1'b0;
    expect_port(RV, 1'b0, "async_reset");
    tick();
    reset_n = 1'b1;
    chk(RV, 1'b0, "after_reset");
    rd(3'd0, {24'h0, RV}, "read_after_reset");
`endif

    idle(3);
    if (rd_q.size() != 0 || port_q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL leftover: got %0d/%0d pending, want 0/0", rd_q.size(), port_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
